// File: rtl/divider64_seq_pkg.sv
// divider64_seq_pkg: shared definitions for the iterative 64-bit divider.
//   - op encodings for RV64M DIV/DIVU/REM/REMU
//   - FSM state type
//   - width/iteration constants and the special-case operand patterns
package divider64_seq_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ITER = 64;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [XLEN-1:0] XLEN_MIN = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/Adder64b_mod.sv
// Adder64b_mod: the ALU's 64-bit adder/subtractor.
//   A, B  : operands
//   SUB   : 1 selects A - B (two's complement: A + ~B + 1)
//   S     : 64-bit sum/difference
//   COUT  : carry out; in subtract mode COUT = 1 means A >= B (no borrow)
module Adder64b_mod (
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        SUB,
    output logic [63:0] S,
    output logic        COUT
);

    assign {COUT, S} = {1'b0, A} + {1'b0, B ^ {64{SUB}}} + {64'd0, SUB};

endmodule

// File: rtl/divider64_seq.sv
// divider64_seq: iterative restoring divider for RV64M DIV/DIVU/REM/REMU.
// One trial subtraction per cycle through the shared 64-bit adder.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high reset
//   start    : request, sampled only in IDLE
//   op       : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b     : dividend, divisor
//   busy     : high in CALC and DONE
//   done     : one-cycle pulse, result valid
//   result   : quotient or remainder, held until the next done
//   div_zero : registered with result; divisor was zero
module divider64_seq
    import divider64_seq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_zero
);

    state_t          state;
    logic [1:0]      op_r;
    logic            neg_q;
    logic            neg_r;
    logic            dz;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic [6:0]      cnt;

    // Start-cycle decode
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            sp_zero;
    logic            sp_ovf;

    // Iteration datapath
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] diff;
    logic            cout;
    logic            take;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic            res_is_rem;
    logic [XLEN-1:0] final_res;

    always_comb begin
        is_signed = (op == OP_DIV) || (op == OP_REM);
        a_neg     = is_signed & a[XLEN-1];
        b_neg     = is_signed & b[XLEN-1];
        a_mag     = a_neg ? (~a + 64'd1) : a;
        b_mag     = b_neg ? (~b + 64'd1) : b;
        sp_zero   = (b == '0);
        sp_ovf    = is_signed && (a == XLEN_MIN) && (b == ALL_ONES);
    end

    assign shifted = {rem[XLEN-2:0], quo[XLEN-1]};

    Adder64b_mod u_adder (
        .A    (shifted),
        .B    (dvs),
        .SUB  (1'b1),
        .S    (diff),
        .COUT (cout)
    );

    // rem[63] set means the 65-bit shifted value is >= 2^64, which always exceeds dvs;
    // the adder's 64-bit difference is still exact in that case.
    always_comb begin
        take       = rem[XLEN-1] | cout;
        rem_nx     = take ? diff : shifted;
        quo_nx     = {quo[XLEN-2:0], take};
        res_is_rem = (op_r == OP_REM) || (op_r == OP_REMU);
        if (res_is_rem) begin
            final_res = neg_r ? (~rem_nx + 64'd1) : rem_nx;
        end else begin
            final_res = neg_q ? (~quo_nx + 64'd1) : quo_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_r     <= 2'b00;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= 7'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dvs   <= b_mag;
                        cnt   <= 7'd0;
                        busy  <= 1'b1;
                        if (sp_zero || sp_ovf) begin
                            // Final values parked in quo/rem; no negation applied later.
                            quo   <= sp_zero ? ALL_ONES : a;
                            rem   <= sp_zero ? a : '0;
                            dz    <= sp_zero;
                            state <= DONE;
                        end else begin
                            quo   <= a_mag;
                            rem   <= '0;
                            dz    <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 7'd1;
                    if (cnt == 7'(ITER - 1)) begin
                        result   <= final_res;
                        div_zero <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // Special-case entry: one settling cycle, then publish and pulse done.
                        result   <= res_is_rem ? rem : quo;
                        div_zero <= dz;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
